// File: rtl/mem_exc_ctrl_if.sv
// Bus between the M stage / CP0 and the address-exception controller.
//   master : pipeline + CP0 side, drives the access and the acknowledge
//   slave  : mem_exc_ctrl, returns the pending exception state
// Signals:
//   m_valid, m_stall, m_load, m_store, m_size[1:0], m_addr[ADDR_W-1:0], exc_ack
//   exc_valid, exc_code[4:0], exc_badva[ADDR_W-1:0], exc_count[CNT_W-1:0]
interface mem_exc_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
);
   logic              m_valid;
   logic              m_stall;
   logic              m_load;
   logic              m_store;
   logic [1:0]        m_size;
   logic [ADDR_W-1:0] m_addr;
   logic              exc_ack;
   logic              exc_valid;
   logic [4:0]        exc_code;
   logic [ADDR_W-1:0] exc_badva;
   logic [CNT_W-1:0]  exc_count;

   modport master (
      output m_valid, m_stall, m_load, m_store, m_size, m_addr, exc_ack,
      input  exc_valid, exc_code, exc_badva, exc_count
   );

   modport slave (
      input  m_valid, m_stall, m_load, m_store, m_size, m_addr, exc_ack,
      output exc_valid, exc_code, exc_badva, exc_count
   );
endinterface

// File: rtl/mem_exc_ctrl.sv
// M-stage address-exception controller.
// Checks every load/store for misalignment, out-of-region access, sub-word
// access to word-only MMIO windows and writes to read-only MMIO words. The
// first fault is latched (code + BadVAddr) until CP0 acknowledges it, and a
// saturating counter tracks how many exceptions have been raised.
// Ports:
//   clk_i      clock, all state on posedge
//   reset_n_i  synchronous reset, active low
//   bus        mem_exc_ctrl_if.slave (M-stage access in, exception state out)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no exception pending, watching the M stage for faults
// PEND  | exception latched, outputs held until exc_ack
module mem_exc_ctrl #(
   parameter int                        ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]         DM_LIMIT   = 32'h0000_3000,
   parameter int                        NUM_WIN    = 3,
   parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE   = {32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00},
   parameter logic [NUM_WIN*ADDR_W-1:0] WIN_LAST   = {32'h0000_7f23, 32'h0000_7f1b, 32'h0000_7f0b},
   parameter logic [NUM_WIN-1:0]        WIN_WORD   = 3'b011,
   parameter logic [NUM_WIN-1:0]        WIN_RO_EN  = 3'b011,
   parameter logic [NUM_WIN*4-1:0]      WIN_RO_OFF = {4'h0, 4'h8, 4'h8},
   parameter int                        CNT_W      = 8
) (
   input logic            clk_i,
   input logic            reset_n_i,
   mem_exc_ctrl_if.slave  bus
);

   localparam logic [4:0] CODE_ADEL = 5'd4;
   localparam logic [4:0] CODE_ADES = 5'd5;

   typedef enum logic {IDLE, PEND} state_t;

   state_t            state_q;
   logic              exc_valid_q;
   logic [4:0]        exc_code_q;
   logic [ADDR_W-1:0] exc_badva_q;
   logic [CNT_W-1:0]  exc_count_q;

   logic              is_word;
   logic              misaligned;
   logic              win_hit;
   logic              win_word_only;
   logic              win_ro_hit;
   logic              fault_d;

   // Size 3 is reserved and behaves as a word access.
   assign is_word = bus.m_size[1];

   always_comb begin
      misaligned = 1'b0;
      if (bus.m_size == 2'd1)
         misaligned = bus.m_addr[0];
      else if (is_word)
         misaligned = (bus.m_addr[1:0] != 2'b00);
   end

   // First matching window (lowest index) decides the window attributes.
   always_comb begin
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] last;
      logic [ADDR_W-1:0] ro_off;
      win_hit       = 1'b0;
      win_word_only = 1'b0;
      win_ro_hit    = 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
         base   = WIN_BASE[i*ADDR_W +: ADDR_W];
         last   = WIN_LAST[i*ADDR_W +: ADDR_W];
         ro_off = {{(ADDR_W-4){1'b0}}, WIN_RO_OFF[i*4 +: 4]};
         if (!win_hit && bus.m_addr >= base && bus.m_addr <= last) begin
            win_hit       = 1'b1;
            win_word_only = WIN_WORD[i];
            win_ro_hit    = WIN_RO_EN[i] && ((bus.m_addr - base) == ro_off);
         end
      end
   end

   always_comb begin
      fault_d = 1'b0;
      if (bus.m_valid && (bus.m_load || bus.m_store)) begin
         fault_d = misaligned
                || ((bus.m_addr >= DM_LIMIT) && !win_hit)
                || (win_hit && win_word_only && !is_word)
                || (win_hit && win_ro_hit && bus.m_store && is_word);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         exc_valid_q <= 1'b0;
         exc_code_q  <= '0;
         exc_badva_q <= '0;
         exc_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // A stalled instruction will be re-presented, so capture only once it moves.
               if (fault_d && !bus.m_stall) begin
                  state_q     <= PEND;
                  exc_valid_q <= 1'b1;
                  exc_code_q  <= bus.m_store ? CODE_ADES : CODE_ADEL;
                  exc_badva_q <= bus.m_addr;
                  if (exc_count_q != {CNT_W{1'b1}})
                     exc_count_q <= exc_count_q + 1'b1;
               end
            end
            PEND: begin
               // Later faults are ignored; a fault arriving with the ack is dropped.
               if (bus.exc_ack) begin
                  state_q     <= IDLE;
                  exc_valid_q <= 1'b0;
                  exc_code_q  <= '0;
                  exc_badva_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.exc_valid = exc_valid_q;
   assign bus.exc_code  = exc_code_q;
   assign bus.exc_badva = exc_badva_q;
   assign bus.exc_count = exc_count_q;

endmodule

// File: tb/tb_mem_exc_ctrl.sv
module tb_mem_exc_ctrl;

   logic clk_sys = 1'b0;
   logic rst_b   = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   always #5 clk_sys = ~clk_sys;

   mem_exc_ctrl_if #(.ADDR_W(32), .CNT_W(8)) bus_if ();

   mem_exc_ctrl dut (
      .clk_i     (clk_sys),
      .reset_n_i (rst_b),
      .bus       (bus_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic drive(input logic ld, input logic st, input logic [1:0] sz,
                        input logic [31:0] a);
      bus_if.m_valid = 1'b1;
      bus_if.m_load  = ld;
      bus_if.m_store = st;
      bus_if.m_size  = sz;
      bus_if.m_addr  = a;
   endtask

   task automatic idle_in();
      bus_if.m_valid = 1'b0;
      bus_if.m_load  = 1'b0;
      bus_if.m_store = 1'b0;
      bus_if.m_size  = 2'd0;
      bus_if.m_addr  = '0;
   endtask

   task automatic exp_exc(input string tag, input logic [4:0] code,
                          input logic [31:0] va, input logic [7:0] cnt);
      chk({tag, ".valid"}, {31'd0, bus_if.exc_valid}, 32'd1);
      chk({tag, ".code"},  {27'd0, bus_if.exc_code}, {27'd0, code});
      chk({tag, ".badva"}, bus_if.exc_badva, va);
      chk({tag, ".count"}, {24'd0, bus_if.exc_count}, {24'd0, cnt});
   endtask

   task automatic exp_none(input string tag, input logic [7:0] cnt);
      chk({tag, ".valid"}, {31'd0, bus_if.exc_valid}, 32'd0);
      chk({tag, ".code"},  {27'd0, bus_if.exc_code}, 32'd0);
      chk({tag, ".badva"}, bus_if.exc_badva, 32'd0);
      chk({tag, ".count"}, {24'd0, bus_if.exc_count}, {24'd0, cnt});
   endtask

   // One access cycle, then idle inputs; outputs reflect the access.
   task automatic access(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] a);
      drive(ld, st, sz, a);
      tick();
      idle_in();
   endtask

   task automatic ack(input string tag, input logic [7:0] cnt);
      bus_if.exc_ack = 1'b1;
      tick();
      bus_if.exc_ack = 1'b0;
      exp_none(tag, cnt);
   endtask

   initial begin
      idle_in();
      bus_if.m_stall = 1'b0;
      bus_if.exc_ack = 1'b0;
      rst_b = 1'b0;
      tick();
      tick();
      exp_none("reset", 8'd0);
      rst_b = 1'b1;

      // misaligned load word
      access(1, 0, 2'd2, 32'h0000_0102);
      exp_exc("lw_mis", 5'd4, 32'h102, 8'd1);
      ack("lw_mis_ack", 8'd1);

      // window rules
      access(0, 1, 2'd0, 32'h0000_7f04);
      exp_exc("sb_win0", 5'd5, 32'h7f04, 8'd2);
      ack("sb_win0_ack", 8'd2);
      access(1, 0, 2'd2, 32'h0000_7f08);
      exp_none("lw_ro_ok", 8'd2);
      access(0, 1, 2'd2, 32'h0000_7f08);
      exp_exc("sw_ro", 5'd5, 32'h7f08, 8'd3);
      ack("sw_ro_ack", 8'd3);
      access(0, 1, 2'd2, 32'h0000_7f20);
      exp_none("sw_win2", 8'd3);

      // region boundaries
      access(1, 0, 2'd1, 32'h0000_3000);
      exp_exc("lh_limit", 5'd4, 32'h3000, 8'd4);
      ack("lh_limit_ack", 8'd4);
      access(1, 0, 2'd2, 32'h0000_2ffc);
      exp_none("lw_dm_top", 8'd4);
      access(1, 0, 2'd2, 32'h0000_7f0c);
      exp_exc("lw_gap", 5'd4, 32'h7f0c, 8'd5);
      ack("lw_gap_ack", 8'd5);

      // extra patterns: half misaligned, window1 sub-word and RO, size 3, invalid
      access(1, 0, 2'd1, 32'h0000_0101);
      exp_exc("lh_mis", 5'd4, 32'h101, 8'd6);
      ack("lh_mis_ack", 8'd6);
      access(0, 1, 2'd1, 32'h0000_7f1a);
      exp_exc("sh_win1", 5'd5, 32'h7f1a, 8'd7);
      ack("sh_win1_ack", 8'd7);
      access(0, 1, 2'd2, 32'h0000_7f18);
      exp_exc("sw_ro1", 5'd5, 32'h7f18, 8'd8);
      ack("sw_ro1_ack", 8'd8);
      access(1, 0, 2'd3, 32'h0000_0202);
      exp_exc("lsz3_mis", 5'd4, 32'h202, 8'd9);
      ack("lsz3_ack", 8'd9);
      drive(1, 0, 2'd2, 32'h0000_0102);
      bus_if.m_valid = 1'b0;
      tick();
      idle_in();
      exp_none("not_valid", 8'd9);
      bus_if.exc_ack = 1'b1;
      tick();
      bus_if.exc_ack = 1'b0;
      exp_none("ack_idle", 8'd9);

      // first cause wins
      access(1, 0, 2'd2, 32'h0000_0102);
      exp_exc("first", 5'd4, 32'h102, 8'd10);
      access(0, 1, 2'd2, 32'h0000_3000);
      exp_exc("second_ign", 5'd4, 32'h102, 8'd10);
      ack("first_ack", 8'd10);

      // ack together with a new fault drops the new fault
      access(1, 0, 2'd2, 32'h0000_0106);
      exp_exc("pre_drop", 5'd4, 32'h106, 8'd11);
      drive(0, 1, 2'd2, 32'h0000_3000);
      bus_if.exc_ack = 1'b1;
      tick();
      bus_if.exc_ack = 1'b0;
      idle_in();
      exp_none("drop", 8'd11);
      tick();
      exp_none("drop_after", 8'd11);

      // stall suppresses capture
      bus_if.m_stall = 1'b1;
      drive(0, 1, 2'd2, 32'h0000_3004);
      for (int k = 0; k < 3; k++) begin
         tick();
         exp_none("stall", 8'd11);
      end
      bus_if.m_stall = 1'b0;
      tick();
      idle_in();
      exp_exc("unstall", 5'd5, 32'h3004, 8'd12);
      bus_if.m_stall = 1'b1;
      ack("ack_stall", 8'd12);
      bus_if.m_stall = 1'b0;

      // reset overrides ack while pending
      access(1, 0, 2'd2, 32'h0000_0102);
      exp_exc("pre_rst", 5'd4, 32'h102, 8'd13);
      rst_b = 1'b0;
      bus_if.exc_ack = 1'b1;
      drive(1, 0, 2'd2, 32'h0000_0102);
      tick();
      exp_none("rst_pend", 8'd0);
      rst_b = 1'b1;
      bus_if.exc_ack = 1'b0;
      idle_in();

      // counter saturation
      for (int k = 0; k < 256; k++) begin
         access(0, 1, 2'd2, 32'h0000_4000);
         bus_if.exc_ack = 1'b1;
         tick();
         bus_if.exc_ack = 1'b0;
         if (k == 253) chk("cnt_254", {24'd0, bus_if.exc_count}, 32'd254);
         if (k == 254) chk("cnt_255", {24'd0, bus_if.exc_count}, 32'd255);
      end
      access(1, 0, 2'd2, 32'h0000_4000);
      exp_exc("sat", 5'd4, 32'h4000, 8'd255);
      ack("sat_ack", 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
